// File: rtl/ipcore_in_fifo.sv
// Input staging FIFO ahead of ipcore: valid/ready in and out, fill level, sticky backpressure flag.
// Define IPCORE_IN_FIFO_FWFT_EN for first-word fall-through; default adds an output register stage.
module ipcore_in_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_W-1:0]      s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_W-1:0]      m_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   bp_seen,
  input  logic                   bp_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] FullLvl = PW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     level_q, level_d;
  logic              bp_q, bp_d;
  logic              push, pop, ram_empty, ram_rd;

  // Full is judged from the registered level only, so m_ready never reaches s_ready.
  assign s_ready   = !rst && (level_q != FullLvl);
  assign push      = s_valid && s_ready;
  assign pop       = m_valid && m_ready;
  assign ram_empty = (wr_ptr_q == rd_ptr_q);
  assign level     = level_q;
  assign bp_seen   = bp_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(ram_rd);
    level_d  = level_q + PW'(push) - PW'(pop);
    bp_d     = bp_q;
    if (s_valid && !s_ready) begin
      bp_d = 1'b1;
    end else if (bp_clr) begin
      bp_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      bp_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      bp_q     <= bp_d;
    end
  end

`ifdef IPCORE_IN_FIFO_FWFT_EN
  logic m_valid_q, m_valid_d;

  assign ram_rd    = pop;
  assign m_valid_d = (level_d != '0);
  assign m_valid   = m_valid_q;
  // Gate the RAM read so m_data is zero rather than stale contents while empty.
  assign m_data    = ram_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
    end
  end
`else
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  // Refill whenever the output stage is empty or being drained this cycle: no bubbles.
  assign ram_rd  = !ram_empty && (!out_valid_q || m_ready);
  assign m_valid = out_valid_q;
  assign m_data  = out_data_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (ram_rd) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_q[rd_ptr_q[AW-1:0]];
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end
`endif

endmodule
